// File: rtl/pcie_tx_pkg.sv
// pcie_tx_pkg
//   Shared definitions for the PCIe VC0 transmit arbiter: FSM state
//   encoding, infinite-credit bit positions and the data-credit unit size.
package pcie_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  // Header credit vectors are 9 bits, data credit vectors 13 bits; the top
  // bit of each flags "infinite credits".
  localparam int PH_INF       = 8;
  localparam int PD_INF       = 12;
  localparam int CRED_UNIT_DW = 4;

endpackage

// File: rtl/pcie_tx_arbiter_credit_chk.sv
// pcie_credit_chk
//   Combinational credit check for one pending TLP.
//   Ports:
//     is_cpl   in  1  : 1 = completion TLP, 0 = posted write
//     len      in  10 : payload length in DW (0 = no payload)
//     ca_ph    in  9  : posted header credits   (bit 8 = infinite)
//     ca_pd    in  13 : posted data credits     (bit 12 = infinite)
//     ca_cplh  in  9  : completion header credits
//     ca_cpld  in  13 : completion data credits
//     ok       out 1  : enough credits to send this TLP now
module pcie_credit_chk
  import pcie_tx_pkg::*;
(
  input  logic        is_cpl,
  input  logic [9:0]  len,
  input  logic [8:0]  ca_ph,
  input  logic [12:0] ca_pd,
  input  logic [8:0]  ca_cplh,
  input  logic [12:0] ca_cpld,
  output logic        ok
);

  logic [10:0] need;
  logic [8:0]  hdr;
  logic [12:0] dat;
  logic        hdr_ok;
  logic        dat_ok;

  // Data credits needed, rounded up to whole credit units; 11 bits so that
  // len=1023 plus the rounding term cannot wrap.
  assign need = (11'(len) + 11'(CRED_UNIT_DW - 1)) / 11'(CRED_UNIT_DW);

  assign hdr = is_cpl ? ca_cplh : ca_ph;
  assign dat = is_cpl ? ca_cpld : ca_pd;

  assign hdr_ok = hdr[PH_INF] | (hdr != 9'd0);
  assign dat_ok = dat[PD_INF] | ({2'b00, need} <= dat);
  assign ok     = hdr_ok & dat_ok;

endmodule

// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter
//   Round-robin arbiter sharing the PCIe core's single VC0 TX port between
//   up to four TLP sources. A grant is issued only when the core advertises
//   enough credits, and is held for exactly one TLP (tx_st .. tx_end).
//   Ports:
//     clk_125, rstn                  : core clock, async active-low reset
//     req/req_cpl/req_len            : per-requester pending flag, type, length
//     req_st/req_end/req_data        : per-requester framing and data
//     gnt                            : one-hot owner of the TX port
//     tx_req/tx_rdy                  : handshake with the core
//     tx_st/tx_end/tx_data           : muxed framing/data to the core
//     tx_ca_* / *_recheck            : core credit vectors and recheck strobes
//     busy                           : a TLP is requested or in flight
//     err_abort                      : pulse when a request is withdrawn in REQ
module pcie_tx_arbiter
  import pcie_tx_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 16
) (
  input  logic              clk_125,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_cpl,
  input  logic [NREQ*10-1:0] req_len,
  input  logic [NREQ-1:0]   req_st,
  input  logic [NREQ-1:0]   req_end,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_req,
  input  logic              tx_rdy,
  output logic              tx_st,
  output logic              tx_end,
  output logic [DW-1:0]     tx_data,
  input  logic [8:0]        tx_ca_ph,
  input  logic [8:0]        tx_ca_cplh,
  input  logic [12:0]       tx_ca_pd,
  input  logic [12:0]       tx_ca_cpld,
  input  logic              tx_ca_p_recheck,
  input  logic              tx_ca_cpl_recheck,
  output logic              busy,
  output logic              err_abort
);

  localparam int SW = (NREQ > 2) ? 2 : 1;

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            tx_req_q, tx_req_d;
  logic            err_abort_q, err_abort_d;

  logic [NREQ-1:0] ok;
  logic [NREQ-1:0] sel_oh;
  logic            req_sel, cpl_sel, ok_sel, st_sel, end_sel, recheck_sel;
  logic            found;
  logic [SW-1:0]   pick;
  int              idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_chk
    pcie_credit_chk u_chk (
      .is_cpl  (req_cpl[i]),
      .len     (req_len[10*i +: 10]),
      .ca_ph   (tx_ca_ph),
      .ca_pd   (tx_ca_pd),
      .ca_cplh (tx_ca_cplh),
      .ca_cpld (tx_ca_cpld),
      .ok      (ok[i])
    );
  end

  // One-hot form of the latched selection, used to pick that requester's
  // signals without variable-width indexing.
  assign sel_oh      = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;
  assign req_sel     = |(req & sel_oh);
  assign cpl_sel     = |(req_cpl & sel_oh);
  assign ok_sel      = |(ok & sel_oh);
  assign st_sel      = |(req_st & sel_oh);
  assign end_sel     = |(req_end & sel_oh);
  assign recheck_sel = cpl_sel ? tx_ca_cpl_recheck : tx_ca_p_recheck;

  // Round-robin search starting one past the last served requester;
  // ineligible requesters are simply skipped.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last_q) + 1 + k) % NREQ;
      if (!found && req[idx] && ok[idx]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    tx_req_d    = tx_req_q;
    err_abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d    = '0;
        tx_req_d = 1'b0;
        if (found) begin
          sel_d    = pick;
          tx_req_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!req_sel) begin
          err_abort_d = 1'b1;
          tx_req_d    = 1'b0;
          state_d     = ST_IDLE;
        end else if (recheck_sel && !ok_sel) begin
          tx_req_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (tx_rdy) begin
          gnt_d   = sel_oh;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (st_sel) tx_req_d = 1'b0;
        if (end_sel) begin
          last_d   = sel_q;
          gnt_d    = '0;
          tx_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        gnt_d    = '0;
        tx_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Control/state register stage
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      last_q      <= SW'(NREQ - 1);
      gnt_q       <= '0;
      tx_req_q    <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      tx_req_q    <= tx_req_d;
      err_abort_q <= err_abort_d;
    end
  end

  // Zero-latency data path: the registered grant steers requester signals
  // straight to the core; everything reads 0 while nobody owns the port.
  always_comb begin
    tx_st   = |(gnt_q & req_st);
    tx_end  = |(gnt_q & req_end);
    tx_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) tx_data = tx_data | req_data[DW*i +: DW];
    end
  end

  assign gnt       = gnt_q;
  assign tx_req    = tx_req_q;
  assign err_abort = err_abort_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
module tb_pcie_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic              clk_125 = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req, req_cpl, req_st, req_end;
  logic [NREQ*10-1:0] req_len;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              tx_req, tx_rdy, tx_st, tx_end;
  logic [DW-1:0]     tx_data;
  logic [8:0]        tx_ca_ph, tx_ca_cplh;
  logic [12:0]       tx_ca_pd, tx_ca_cpld;
  logic              tx_ca_p_recheck, tx_ca_cpl_recheck;
  logic              busy, err_abort;

  int n_cmp = 0;
  int n_mis = 0;

  always #4 clk_125 = ~clk_125;

  pcie_tx_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk_125           (clk_125),
    .rstn              (rstn),
    .req               (req),
    .req_cpl           (req_cpl),
    .req_len           (req_len),
    .req_st            (req_st),
    .req_end           (req_end),
    .req_data          (req_data),
    .gnt               (gnt),
    .tx_req            (tx_req),
    .tx_rdy            (tx_rdy),
    .tx_st             (tx_st),
    .tx_end            (tx_end),
    .tx_data           (tx_data),
    .tx_ca_ph          (tx_ca_ph),
    .tx_ca_cplh        (tx_ca_cplh),
    .tx_ca_pd          (tx_ca_pd),
    .tx_ca_cpld        (tx_ca_cpld),
    .tx_ca_p_recheck   (tx_ca_p_recheck),
    .tx_ca_cpl_recheck (tx_ca_cpl_recheck),
    .busy              (busy),
    .err_abort         (err_abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_125);
  endtask

  task automatic set_infinite();
    tx_ca_ph   = 9'h100;
    tx_ca_cplh = 9'h100;
    tx_ca_pd   = 13'h1000;
    tx_ca_cpld = 13'h1000;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // Starts in IDLE with req[who] eligible and highest in round-robin order;
  // runs one single-cycle TLP and returns in IDLE.
  task automatic xfer_one(input int who, input string tag);
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = 4'b0001 << who;
    step();
    check($sformatf("%s_txreq", tag), 32'(tx_req), 32'd1);
    check($sformatf("%s_gnt_pre", tag), 32'(gnt), 32'd0);
    tx_rdy = 1'b1;
    step();
    tx_rdy = 1'b0;
    check($sformatf("%s_gnt", tag), 32'(gnt), 32'(exp_gnt));
    req_st  = '1;
    req_end = '1;
    #1;
    check($sformatf("%s_st", tag), 32'(tx_st), 32'd1);
    check($sformatf("%s_end", tag), 32'(tx_end), 32'd1);
    check($sformatf("%s_data", tag), 32'(tx_data), 32'(16'hD000 + 16'(who)));
    step();
    req_st  = '0;
    req_end = '0;
    check($sformatf("%s_gnt_clr", tag), 32'(gnt), 32'd0);
    check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    req = '0; req_cpl = '0; req_st = '0; req_end = '0;
    req_len = '0; tx_rdy = 1'b0;
    tx_ca_ph = '0; tx_ca_cplh = '0; tx_ca_pd = '0; tx_ca_cpld = '0;
    tx_ca_p_recheck = 1'b0; tx_ca_cpl_recheck = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[DW*i +: DW] = 16'hD000 + 16'(i);

    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_txreq", 32'(tx_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_abort", 32'(err_abort), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    step();
    rstn = 1'b1;

    // Single posted write from requester 1: len 8 needs 2 data credits.
    tx_ca_ph = 9'd4;
    tx_ca_pd = 13'd2;
    req_len[19:10] = 10'd8;
    req[1] = 1'b1;
    #1;
    check("pw_txreq_n", 32'(tx_req), 32'd0);
    step();
    check("pw_txreq_n1", 32'(tx_req), 32'd1);
    check("pw_busy", 32'(busy), 32'd1);
    check("pw_gnt_req", 32'(gnt), 32'd0);
    tx_rdy = 1'b1;
    step();
    tx_rdy = 1'b0;
    check("pw_gnt", 32'(gnt), 32'b0010);
    req_st[1] = 1'b1;
    req_data[31:16] = 16'hA5A5;
    #1;
    check("pw_st", 32'(tx_st), 32'd1);
    check("pw_data0", 32'(tx_data), 32'hA5A5);
    check("pw_txreq_st", 32'(tx_req), 32'd1);
    step();
    req_st[1] = 1'b0;
    req_data[31:16] = 16'h1234;
    #1;
    check("pw_txreq_clr", 32'(tx_req), 32'd0);
    check("pw_data1", 32'(tx_data), 32'h1234);
    check("pw_st_low", 32'(tx_st), 32'd0);
    req_end[1] = 1'b1;
    #1;
    check("pw_end", 32'(tx_end), 32'd1);
    step();
    req_end[1] = 1'b0;
    req[1] = 1'b0;
    req_data[31:16] = 16'hD001;
    check("pw_gnt_clr", 32'(gnt), 32'd0);
    check("pw_idle", 32'(busy), 32'd0);
    check("pw_data_nognt", 32'(tx_data), 32'd0);

    // Round-robin from reset with all requesters pending.
    do_reset();
    set_infinite();
    req = 4'b1111;
    xfer_one(0, "rr0");
    xfer_one(1, "rr1");
    xfer_one(2, "rr2");
    xfer_one(3, "rr3");
    xfer_one(0, "rr4");
    req = '0;

    // Credit gating: requester 0 needs 4 posted data credits, only 3 offered.
    do_reset();
    tx_ca_ph   = 9'd4;
    tx_ca_pd   = 13'd3;
    tx_ca_cplh = 9'd1;
    tx_ca_cpld = 13'd0;
    req_len[9:0]   = 10'd16;
    req_len[29:20] = 10'd0;
    req_cpl = 4'b0100;
    req     = 4'b0101;
    xfer_one(2, "cg2");
    req = 4'b0001;
    step();
    check("cg_hold", 32'(tx_req), 32'd0);
    tx_ca_pd = 13'd4;
    xfer_one(0, "cg0");

    // Recheck abort while in REQ.
    step();
    check("rc_txreq", 32'(tx_req), 32'd1);
    tx_ca_pd = 13'd0;
    tx_ca_p_recheck = 1'b1;
    step();
    tx_ca_p_recheck = 1'b0;
    check("rc_txreq_drop", 32'(tx_req), 32'd0);
    check("rc_idle", 32'(busy), 32'd0);
    check("rc_gnt", 32'(gnt), 32'd0);
    check("rc_noabort", 32'(err_abort), 32'd0);
    step();
    check("rc_stay", 32'(tx_req), 32'd0);
    req = '0;

    // Withdrawn request from requester 3.
    set_infinite();
    req_cpl = '0;
    req = 4'b1000;
    step();
    check("wd_txreq", 32'(tx_req), 32'd1);
    req = '0;
    #1;
    check("wd_abort_pre", 32'(err_abort), 32'd0);
    step();
    check("wd_abort", 32'(err_abort), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_txreq_drop", 32'(tx_req), 32'd0);
    step();
    check("wd_abort_once", 32'(err_abort), 32'd0);

    // Asynchronous reset in the middle of a transfer (last served was 0).
    req = 4'b0110;
    step();
    check("mr_txreq", 32'(tx_req), 32'd1);
    tx_rdy = 1'b1;
    step();
    tx_rdy = 1'b0;
    check("mr_gnt", 32'(gnt), 32'b0010);
    req_st = 4'b0010;
    #1;
    check("mr_st", 32'(tx_st), 32'd1);
    rstn = 1'b0;
    #1;
    check("mr_rst_gnt", 32'(gnt), 32'd0);
    check("mr_rst_txreq", 32'(tx_req), 32'd0);
    check("mr_rst_st", 32'(tx_st), 32'd0);
    check("mr_rst_busy", 32'(busy), 32'd0);
    req_st = '0;
    req = 4'b1111;
    step();
    rstn = 1'b1;
    xfer_one(0, "mr_after");
    req = '0;

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Shares the single VC0 transmit port of the PCIe core (`tx_req`/`tx_rdy`/`tx_st`/`tx_end`/`tx_data`) between up to four TLP sources:
- the BAR completion engine;
- the PHY1 and PHY2 receive DMA writers;
- the interrupt/status writer.

It sits between `ethpipe_mid`'s TLP generators and `pcie_top`. It applies round-robin arbitration, gates each grant on the core's advertised TX credits, and holds the grant for exactly one TLP (`tx_st` through `tx_end`).

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..4).
- `DW`, 16: TLP data width, matching the core.

Ports (reset `rstn`, asynchronous, active-low; clock `clk_125`):
- `clk_125` in 1: core user clock.
- `rstn` in 1: async active-low reset.
- `req` in NREQ: per-requester TLP-pending, level.
- `req_cpl` in NREQ: 1 = completion TLP, 0 = posted write; stable while `req` is high.
- `req_len` in NREQ*10: payload length in DW, flattened, requester i at [10i+9:10i]; 0 = no payload.
- `req_st`, `req_end` in NREQ: per-requester framing.
- `req_data` in NREQ*DW: per-requester data, flattened.
- `gnt` out NREQ: one-hot; requester i owns the port while high.
- `tx_req` out 1: to core.
- `tx_rdy` in 1: from core.
- `tx_st`, `tx_end` out 1: muxed framing to core.
- `tx_data` out DW: muxed data to core.
- `tx_ca_ph`, `tx_ca_cplh` in 9: header credits; bit 8 = infinite.
- `tx_ca_pd`, `tx_ca_cpld` in 13: data credits in 4-DW units; bit 12 = infinite.
- `tx_ca_p_recheck`, `tx_ca_cpl_recheck` in 1: core credit-recheck strobes.
- `busy` out 1: a TLP is in flight.
- `err_abort` out 1: one-cycle pulse when a pending request is withdrawn before grant.

## Operation
- **States:** IDLE, REQ, XFER.
- **IDLE:**
  - Eligible requester: `req[i]`=1 and credits sufficient.
  - Posted requires `tx_ca_ph`≠0 and `tx_ca_pd` ≥ ceil(len/4).
  - Completion requires `tx_ca_cplh`≠0 and `tx_ca_cpld` ≥ ceil(len/4).
  - An infinite bit satisfies its check.
  - The round-robin pointer starts at `last+1`; the first eligible requester wins and is latched as `sel`; go to REQ.
  - No eligible requester: stay in IDLE. An ineligible requester does not block lower-priority eligible ones.
- **REQ:**
  - `tx_req`=1.
  - If `req[sel]` drops: pulse `err_abort`, return to IDLE, `last` unchanged.
  - If the matching recheck strobe (`tx_ca_p_recheck` for posted, `tx_ca_cpl_recheck` for completion) fires and credits are now insufficient: drop `tx_req`, return to IDLE.
  - On `tx_rdy`=1: `gnt[sel]`=1 from the next cycle; go to XFER.
- **XFER:**
  - `tx_st`/`tx_end`/`tx_data` = `req_*[sel]`, pure combinational mux from the registered `gnt`.
  - `tx_req` is cleared in the cycle `req_st[sel]`=1.
  - On `req_end[sel]`: `last`←`sel`, `gnt` clears next cycle, go to IDLE.
- **Outputs when no grant:** `tx_st`, `tx_end`, `tx_data` are 0.
- **`tx_rdy` outside REQ:** ignored.
- **Single-cycle TLP:** `req_st` and `req_end` in the same cycle is legal.
- **Reset (async, any state):** state=IDLE, `gnt`=0, `tx_req`=0, `busy`=0, `err_abort`=0, `last`=NREQ-1. Requester 0 therefore has first priority after reset.

## Timing
- **`req` to `tx_req`:** `req` sampled in cycle n gives `tx_req`=1 in n+1 (registered).
- **`tx_rdy` to `gnt`:** `tx_rdy` in cycle m gives `gnt` in m+1. The requester may assert `req_st` in m+1 at the earliest.
- **Mux:** zero added latency from `req_*` to `tx_*`.
- **Back-to-back:** `req_end` in cycle k gives IDLE in k+1 and the next `tx_req` in k+2. Minimum gap is 2 cycles.
- **`busy`:** 1 in REQ and XFER.
- **Credit width:** credits are compared at full width. ceil(len/4) = (len+3)>>2, computed in 11 bits.

## Structure
- Shared package `pcie_tx_pkg`:
  - state encoding (IDLE=0, REQ=1, XFER=2);
  - credit infinite-bit positions (PH_INF=8, PD_INF=12);
  - `CRED_UNIT_DW`=4.
- One sub-module, `pcie_credit_chk`: combinational; inputs type, len and credit vectors; output `ok`. Instantiated once per requester.

## Test plan
- **Single posted write:** `req[1]`, len=8, `tx_ca_ph`=4, `tx_ca_pd`=2. Expect `tx_req` at n+1; `tx_rdy` at m gives `gnt`=4'b0010 at m+1; `tx_data` mirrors `req_data[1]`; IDLE after `req_end`.
- **Round-robin:** all four requesters held high with infinite credits. Expect grant order 0,1,2,3,0, each `gnt` one-hot and never overlapping.
- **Credit gating:** `req[0]` posted len=16 with `tx_ca_pd`=3, plus `req[2]` completion len=0 with `tx_ca_cplh`=1. Expect `gnt` goes to 2 only. After `tx_ca_pd`=4, requester 0 is granted.
- **Recheck abort:** in REQ, set `tx_ca_pd`=0 and pulse `tx_ca_p_recheck`. Expect `tx_req` low next cycle, state IDLE, no `gnt`.
- **Withdrawn request:** drop `req[3]` in REQ. Expect a one-cycle `err_abort` pulse and IDLE.
- **Mid-XFER reset:** deassert `rstn` during XFER. Expect `gnt`=0, `tx_req`=0, `tx_st`=0 immediately. After release, requester 0 has first priority.
